// File: rtl/spi_host_master.sv
// SPI mode-0 host master: after reset sends a one-byte 0x11 init frame, then turns each
// accepted command into a 4-byte LSB-first frame and reports MISO bytes 1 and 2.
module spi_host_master #(
    parameter int CLK_DIV   = 4,
    parameter int BYTE_GAP  = 64,
    parameter int FRAME_GAP = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_op,
    input  logic [7:0] cmd_payload,
    output logic       rsp_valid,
    output logic [7:0] rsp_status,
    output logic [7:0] rsp_data,
    output logic       init_done,
    output logic       spi_sck,
    output logic       spi_ss,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int GAP_MAX = (BYTE_GAP > FRAME_GAP) ? BYTE_GAP : FRAME_GAP;
    localparam int CNT_MAX = (GAP_MAX > CLK_DIV) ? GAP_MAX : CLK_DIV;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BG_LOAD  = CW'(BYTE_GAP - 1);
    localparam logic [CW-1:0] FG_LOAD  = CW'(FRAME_GAP - 1);
    // The synchroniser delays MISO by two clocks, so the value present at the SCK
    // rising edge reaches miso_s2_q two cycles into the high phase.
    localparam logic [CW-1:0] SAMPLE_AT = CW'(CLK_DIV - 2);

    typedef enum logic [2:0] {
        INIT_LOAD,
        IDLE,
        SS_SETUP,
        SHIFT,
        BYTE_GAP_WAIT,
        FRAME_END,
        FRAME_GAP_WAIT
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [1:0]    byte_q;
    logic [1:0]    last_byte_q;
    logic [31:0]   tx_q;
    logic [23:0]   rx_q;
    logic          init_frame_q;
    logic          miso_s1_q, miso_s2_q;
    logic          sck_q, ss_q, mosi_q;
    logic          ready_q, rsp_valid_q, init_done_q;
    logic [7:0]    status_q, data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            miso_s1_q <= spi_miso;
            miso_s2_q <= miso_s1_q;
        end
    end

    // NOTE: every register here uses <= so all next-state values are computed from
    // the same pre-edge snapshot; blocking writes would leak updates into later reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT_LOAD;
            cnt_q        <= '0;
            bit_q        <= '0;
            byte_q       <= '0;
            last_byte_q  <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            init_frame_q <= 1'b0;
            sck_q        <= 1'b0;
            ss_q         <= 1'b1;
            mosi_q       <= 1'b0;
            ready_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            init_done_q  <= 1'b0;
            status_q     <= '0;
            data_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                INIT_LOAD: begin
                    tx_q         <= 32'h0000_0011;
                    mosi_q       <= 1'b1;
                    last_byte_q  <= 2'd0;
                    byte_q       <= 2'd0;
                    init_frame_q <= 1'b1;
                    ss_q         <= 1'b0;
                    cnt_q        <= DIV_LOAD;
                    state_q      <= SS_SETUP;
                end
                IDLE: begin
                    if (cmd_valid && ready_q) begin
                        tx_q         <= {16'h0000, cmd_payload, cmd_op};
                        mosi_q       <= cmd_op[0];
                        last_byte_q  <= 2'd3;
                        byte_q       <= 2'd0;
                        init_frame_q <= 1'b0;
                        ready_q      <= 1'b0;
                        ss_q         <= 1'b0;
                        cnt_q        <= DIV_LOAD;
                        state_q      <= SS_SETUP;
                    end
                end
                SS_SETUP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        bit_q   <= '0;
                        cnt_q   <= DIV_LOAD;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sck_q && cnt_q == SAMPLE_AT) begin
                        rx_q <= {miso_s2_q, rx_q[23:1]};
                    end
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (!sck_q) begin
                        sck_q <= 1'b1;
                        cnt_q <= DIV_LOAD;
                    end else begin
                        // Falling edge: MOSI advances so the next bit is stable well before its rise.
                        sck_q  <= 1'b0;
                        tx_q   <= tx_q >> 1;
                        mosi_q <= tx_q[1];
                        bit_q  <= bit_q + 3'd1;
                        if (bit_q != 3'd7) begin
                            cnt_q <= DIV_LOAD;
                        end else if (byte_q == last_byte_q) begin
                            cnt_q   <= DIV_LOAD;
                            state_q <= FRAME_END;
                        end else begin
                            byte_q  <= byte_q + 2'd1;
                            cnt_q   <= BG_LOAD;
                            state_q <= BYTE_GAP_WAIT;
                        end
                    end
                end
                BYTE_GAP_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        cnt_q   <= DIV_LOAD;
                        state_q <= SHIFT;
                    end
                end
                FRAME_END: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        ss_q    <= 1'b1;
                        cnt_q   <= FG_LOAD;
                        state_q <= FRAME_GAP_WAIT;
                        if (!init_frame_q) begin
                            rsp_valid_q <= 1'b1;
                            status_q    <= rx_q[7:0];
                            data_q      <= rx_q[15:8];
                        end
                    end
                end
                FRAME_GAP_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        init_done_q <= 1'b1;
                        ready_q     <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= INIT_LOAD;
            endcase
        end
    end

    assign cmd_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = status_q;
    assign rsp_data   = data_q;
    assign init_done  = init_done_q;
    assign spi_sck    = sck_q;
    assign spi_ss     = ss_q;
    assign spi_mosi   = mosi_q;

endmodule
